// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot decoder with enable and a prescaled auto-scan mode.
// Direct mode follows a. Scan mode steps idx once every DIV enabled cycles.
module dec_scan_n #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      a,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int W  = 2 ** N;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [N-1:0]  IDX_MAX = '1;

    logic [W-1:0]  y_q, y_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic [N-1:0]  idx_inc;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] v);
        logic [W-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        y_d    = y_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (!en) begin
            // idx and cnt hold so a resumed scan keeps its phase
            y_d = '0;
        end else if (!mode || load) begin
            idx_d = a;
            y_d   = onehot(a);
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            idx_d  = idx_inc;
            y_d    = onehot(idx_inc);
            wrap_d = (idx_q == IDX_MAX);
        end else begin
            cnt_d = cnt_q + 1'b1;
            y_d   = onehot(idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
